instr_window_fifo: RTL

Parametrised circular byte buffer for the instruction front end. Producer pushes 1..WR_WIN bytes per cycle under valid/ready; the decoder sees a RD_WIN-byte lookahead window and consumes 1..RD_WIN bytes per cycle. Proper full/empty tracking, wrap-around, flush and end-of-stream detection are included. Sits between the module loader and the instruction decoder.

---
 rtl/instr_window_fifo_pkg.sv | 29 ++
 rtl/instr_window_fifo_rd_mux.sv | 43 ++++
 rtl/instr_window_fifo.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/instr_window_fifo_pkg.sv
// -----------------------------------------------------------------------------
// instr_window_fifo_pkg
//
// Shared defaults and small helpers for the instruction-window byte FIFO.
// The FIFO top and its read-window mux import this package.
//
// Contents:
//   BYTE_W_DEF  - bits per instruction byte
//   DEPTH_DEF   - buffer depth in bytes (power of two)
//   WR_WIN_DEF  - max bytes accepted per write (power of two)
//   RD_WIN_DEF  - lookahead window width in bytes (power of two)
//   clog2_min1  - ceil(log2(n)), never less than 1, for count-field widths
// -----------------------------------------------------------------------------
package instr_window_fifo_pkg;

    localparam int BYTE_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;
    localparam int WR_WIN_DEF = 4;
    localparam int RD_WIN_DEF = 8;

    // Width of a "count minus one" field for a window of n bytes. A window of
    // one byte would still need a one-bit field to give the port a legal width.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : instr_window_fifo_pkg

// File: rtl/instr_window_fifo_rd_mux.sv
// -----------------------------------------------------------------------------
// instr_win_rd_mux
//
// Builds the decoder's lookahead window from the circular storage. Byte k of
// the window is storage[(rd_ptr + k) mod DEPTH]; bytes at or beyond rd_avail
// are forced to zero so the decoder never sees stale buffer contents.
//
// Ports:
//   rd_ptr    in   AW             index of the oldest held byte
//   rd_avail  in   log2(RD_WIN)+1 number of valid bytes in the window
//   mem       in   DEPTH x BYTE_W storage array
//   rd_win    out  RD_WIN*BYTE_W  window, byte 0 (oldest) in the LSBs
// -----------------------------------------------------------------------------
module instr_win_rd_mux
    import instr_window_fifo_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_WIN = RD_WIN_DEF,
    parameter int AW     = $clog2(DEPTH),
    parameter int RAW    = $clog2(RD_WIN) + 1
) (
    input  logic [AW-1:0]            rd_ptr,
    input  logic [RAW-1:0]           rd_avail,
    input  logic [BYTE_W-1:0]        mem [DEPTH],
    output logic [RD_WIN*BYTE_W-1:0] rd_win
);

    always_comb begin
        // NOTE: give every combinational output a default before any
        // conditional assignment; a path that leaves it unassigned would
        // infer a latch.
        rd_win = '0;
        for (int k = 0; k < RD_WIN; k++) begin
            // The AW-bit add wraps modulo DEPTH, which makes the window
            // seamless across the DEPTH-1 -> 0 boundary.
            if (RAW'(k) < rd_avail) begin
                rd_win[k*BYTE_W +: BYTE_W] = mem[rd_ptr + AW'(k)];
            end
        end
    end

endmodule : instr_win_rd_mux

// File: rtl/instr_window_fifo.sv
// -----------------------------------------------------------------------------
// instr_window_fifo
//
// Circular byte buffer between the module loader and the instruction decoder.
// The loader pushes 1..WR_WIN bytes per cycle; the decoder sees the oldest
// RD_WIN bytes as a lookahead window and consumes 1..RD_WIN bytes per cycle.
// Tracks full/empty via an explicit occupancy count, flags illegal consumes,
// and reports end-of-stream once the last write has been fully drained.
//
// Ports:
//   clk           in   1              rising-edge clock
//   rst_n         in   1              asynchronous active-low reset
//   wr_vld        in   1              write request
//   wr_rdy        out  1              room for a full WR_WIN-byte write
//   wr_cnt_m1     in   log2(WR_WIN)   bytes in this write minus one
//   wr_data       in   WR_WIN*BYTE_W  byte k at [k*BYTE_W +: BYTE_W], 0 first
//   wr_last       in   1              this write ends the instruction stream
//   flush         in   1              discard contents, clear flags
//   rd_win        out  RD_WIN*BYTE_W  oldest RD_WIN bytes, byte 0 = oldest
//   rd_avail      out  log2(RD_WIN)+1 valid bytes in rd_win
//   shift_vld     in   1              consume request
//   shift_m1      in   log2(RD_WIN)   bytes consumed minus one
//   shift_err     out  1              sticky illegal-consume flag
//   occupancy     out  AW+1           bytes currently held
//   instr_finish  out  1              end-of-stream seen and buffer empty
//
// All outputs depend only on registered state.
// -----------------------------------------------------------------------------
module instr_window_fifo
    import instr_window_fifo_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WR_WIN = WR_WIN_DEF,
    parameter int RD_WIN = RD_WIN_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_vld,
    output logic                          wr_rdy,
    input  logic [clog2_min1(WR_WIN)-1:0] wr_cnt_m1,
    input  logic [WR_WIN*BYTE_W-1:0]      wr_data,
    input  logic                          wr_last,
    input  logic                          flush,
    output logic [RD_WIN*BYTE_W-1:0]      rd_win,
    output logic [$clog2(RD_WIN):0]       rd_avail,
    input  logic                          shift_vld,
    input  logic [clog2_min1(RD_WIN)-1:0] shift_m1,
    output logic                          shift_err,
    output logic [AW:0]                   occupancy,
    output logic                          instr_finish
);

    localparam int WCW = clog2_min1(WR_WIN);
    localparam int RAW = $clog2(RD_WIN) + 1;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;
    logic              last_seen;
    logic              err_q;
    logic [BYTE_W-1:0] mem [DEPTH];

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic [AW:0]    wr_n;
    logic [AW:0]    sh_n;
    logic [RAW-1:0] sh_req;
    logic           sh_legal;
    logic           wr_fire;
    logic           sh_fire;
    logic           sh_bad;

    assign wr_n   = (AW+1)'(wr_cnt_m1) + (AW+1)'(1);
    assign sh_n   = (AW+1)'(shift_m1) + (AW+1)'(1);
    assign sh_req = RAW'(shift_m1) + RAW'(1);

    // The window never reaches beyond held bytes, so checking against
    // rd_avail also guarantees occupancy cannot underflow.
    assign sh_legal = (sh_req <= rd_avail);

    // Ready is judged on the pre-shift occupancy only; a shift in the same
    // cycle does not lend its freed space to the write.
    assign wr_rdy = (occ <= (AW+1)'(DEPTH - WR_WIN));

    // Flush takes priority over both data movements in the same cycle.
    assign wr_fire = wr_vld && wr_rdy && !flush;
    assign sh_fire = shift_vld && sh_legal && !flush;
    assign sh_bad  = shift_vld && !sh_legal && !flush;

    // ---------------------------------------------------------------------
    // Pointers, occupancy and flags
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is assigned with <= so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            last_seen <= 1'b0;
            err_q     <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            last_seen <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(wr_n);
                if (wr_last) begin
                    last_seen <= 1'b1;
                end
            end
            if (sh_fire) begin
                rd_ptr <= rd_ptr + AW'(sh_n);
            end
            if (sh_bad) begin
                err_q <= 1'b1;
            end
            occ <= occ + (wr_fire ? wr_n : '0) - (sh_fire ? sh_n : '0);
        end
    end

    // ---------------------------------------------------------------------
    // Byte storage
    // ---------------------------------------------------------------------
    // NOTE: the storage array has no reset; occupancy and the rd_avail mask
    // make its power-up contents unobservable, and leaving it out keeps the
    // array mappable to plain flops or RAM without a reset tree.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WR_WIN; k++) begin
            if (wr_fire && (WCW'(k) <= wr_cnt_m1)) begin
                mem[wr_ptr + AW'(k)] <= wr_data[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read window
    // ---------------------------------------------------------------------
    assign rd_avail = (occ >= (AW+1)'(RD_WIN)) ? RAW'(RD_WIN) : RAW'(occ);

    instr_win_rd_mux #(
        .BYTE_W (BYTE_W),
        .DEPTH  (DEPTH),
        .RD_WIN (RD_WIN),
        .AW     (AW),
        .RAW    (RAW)
    ) u_rd_mux (
        .rd_ptr   (rd_ptr),
        .rd_avail (rd_avail),
        .mem      (mem),
        .rd_win   (rd_win)
    );

    // ---------------------------------------------------------------------
    // Status outputs
    // ---------------------------------------------------------------------
    assign occupancy    = occ;
    assign shift_err    = err_q;
    assign instr_finish = last_seen && (occ == '0);

endmodule : instr_window_fifo
